// File: rtl/regression_pkg.sv
// ---------------------------------------------------------------------------
// regression_pkg
// Shared definitions for the linear-regression accumulator datapath.
//   DATA_W     sample width (two's complement, Q(DATA_W-FRAC_W).FRAC_W)
//   FRAC_W     fractional bits per sample
//   fxp_t      one signed sample
//   fxp_prod_t full-precision signed product of two samples
//   state_t    control states of the accumulator run
// ---------------------------------------------------------------------------
package regression_pkg;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 10;

  typedef logic signed [DATA_W-1:0]   fxp_t;
  typedef logic signed [2*DATA_W-1:0] fxp_prod_t;

  // IDLE  : waiting for the first start after reset
  // ACCUM : taking samples until N have been accepted
  // DRAIN : last sample still travelling through the MAC pipeline
  // DONE  : sums final and held until the next start
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fxp_mac_stage.sv
// ---------------------------------------------------------------------------
// fxp_mac_stage
// Two-stage multiply/accumulate lane.
//   S1 registers operand b and the full-precision signed product a*b.
//   S2 sign-extends both and adds them into a linear sum (of b) and a
//   product sum (of a*b).
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (clears everything)
//   clear     synchronous clear of S1 valid and both accumulators
//   in_valid  a/b accepted this cycle
//   a, b      signed operands, IN_W bits
//   s1_valid  S1 holds a beat that S2 has not yet absorbed
//   sum_lin   running sum of b, LIN_W bits signed
//   sum_prod  running sum of a*b, PROD_W bits signed
// ---------------------------------------------------------------------------
module fxp_mac_stage
  import regression_pkg::*;
#(
  parameter int IN_W   = DATA_W,
  parameter int LIN_W  = DATA_W + 8,
  parameter int PROD_W = 2*DATA_W + 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [IN_W-1:0]   a,
  input  logic signed [IN_W-1:0]   b,
  output logic                     s1_valid,
  output logic signed [LIN_W-1:0]  sum_lin,
  output logic signed [PROD_W-1:0] sum_prod
);

  logic signed [IN_W-1:0]   b_reg;
  logic signed [2*IN_W-1:0] prod_reg;
  logic signed [2*IN_W-1:0] prod_next;

  // Widen both operands before multiplying so the product keeps every bit,
  // including the -max * -max corner.
  assign prod_next = (2*IN_W)'(a) * (2*IN_W)'(b);

  // S1: operand / product capture. Data registers only load on a real beat
  // so bubbles leave them untouched; only s1_valid tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      b_reg    <= '0;
      prod_reg <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        b_reg    <= b;
        prod_reg <= prod_next;
      end
    end
  end

  // S2: accumulate. Accumulator widths carry enough headroom that no
  // sequence of samples of the configured length can overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_lin  <= '0;
      sum_prod <= '0;
    end else if (clear) begin
      sum_lin  <= '0;
      sum_prod <= '0;
    end else if (s1_valid) begin
      sum_lin  <= sum_lin  + LIN_W'(b_reg);
      sum_prod <= sum_prod + PROD_W'(prod_reg);
    end
  end

endmodule

// File: rtl/regression_accumulator.sv
// ---------------------------------------------------------------------------
// regression_accumulator
// Streams N signed (x,y) samples over a valid/ready handshake and produces
// sum_x, sum_y, sum_xy and sum_xx for the regression coefficient stage.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   start     begin a run (honoured only in IDLE or DONE)
//   x, y      samples, Q10.10 signed
//   in_valid  x/y valid
//   in_ready  sample accepted this cycle when in_valid is high
//   busy      run in progress (ACCUM or DRAIN)
//   done      sums final; held until the next start
//   count     samples accepted in the current run
//   sum_x     Q18.10 signed sum of x
//   sum_y     Q18.10 signed sum of y
//   sum_xy    Q28.20 signed sum of x*y
//   sum_xx    Q28.20 signed sum of x*x
// ---------------------------------------------------------------------------
module regression_accumulator
  import regression_pkg::*;
#(
  parameter  int N     = 150,
  localparam int CNT_W = $clog2(N + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic signed [DATA_W-1:0]         x,
  input  logic signed [DATA_W-1:0]         y,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             busy,
  output logic                             done,
  output logic [CNT_W-1:0]                 count,
  output logic signed [DATA_W+CNT_W-1:0]   sum_x,
  output logic signed [DATA_W+CNT_W-1:0]   sum_y,
  output logic signed [2*DATA_W+CNT_W-1:0] sum_xy,
  output logic signed [2*DATA_W+CNT_W-1:0] sum_xx
);

  state_t state_reg;
  state_t state_next;

  logic accept;
  logic run_clear;
  logic count_full;
  logic s1_valid_xy;
  logic s1_valid_xx;
  logic pipe_busy;

  // A start is only meaningful when no run is in flight; the same edge that
  // moves us into ACCUM wipes the counter and both MAC lanes.
  assign run_clear  = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign count_full = (count == CNT_W'(N));
  assign accept     = in_valid && in_ready;
  assign pipe_busy  = s1_valid_xy || s1_valid_xx;

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start)      state_next = ACCUM;
      ACCUM: if (count_full) state_next = DRAIN;
      // S1 can only hold the final beat for one cycle after the last
      // accept, so DRAIN normally lasts exactly one cycle.
      DRAIN: if (!pipe_busy) state_next = DONE;
      DONE:  if (start)      state_next = ACCUM;
      default:               state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------- outputs
  // All three are decodes of the state and count registers, so they change
  // only on clock edges (or reset). in_ready is low in IDLE/DONE, which is
  // what keeps a beat presented alongside start from being taken.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_reg)
      ACCUM: begin
        in_ready = !count_full;
        busy     = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------- counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (run_clear) begin
      count <= '0;
    end else if (accept) begin
      count <= count + CNT_W'(1);
    end
  end

  // ------------------------------------------------------------ MAC lanes
  // The (x,y) lane supplies sum_y and sum_xy; the (x,x) lane supplies
  // sum_x and sum_xx, since its linear sum is over its b operand.
  fxp_mac_stage #(
    .IN_W   (DATA_W),
    .LIN_W  (DATA_W + CNT_W),
    .PROD_W (2*DATA_W + CNT_W)
  ) u_mac_xy (
    .clk      (clk),
    .rst      (rst),
    .clear    (run_clear),
    .in_valid (accept),
    .a        (x),
    .b        (y),
    .s1_valid (s1_valid_xy),
    .sum_lin  (sum_y),
    .sum_prod (sum_xy)
  );

  fxp_mac_stage #(
    .IN_W   (DATA_W),
    .LIN_W  (DATA_W + CNT_W),
    .PROD_W (2*DATA_W + CNT_W)
  ) u_mac_xx (
    .clk      (clk),
    .rst      (rst),
    .clear    (run_clear),
    .in_valid (accept),
    .a        (x),
    .b        (x),
    .s1_valid (s1_valid_xx),
    .sum_lin  (sum_x),
    .sum_prod (sum_xx)
  );

endmodule
